loop_interface_segmenter: RTL and testbench
===========================================

// Module: loop_interface_segmenter
// PURPOSE
//   Parametrised loopback handler. Pops one IN_W-bit word from the receive-side FIFO and splits it
//   into NUM_PARTS = ceil(IN_W/OUT_W) segments. Writes each segment to the transmit-side FIFO with a
//   ready/write handshake. Sits in the test core between transceiver RX read port and TX write port.
//   Generalises the fixed 56->2x34 handler: any widths, selectable segment order, back-to-back words,
//   completed-word counter.
// PARAMETERS
//   IN_W       56  width of received word (>=1)
//   OUT_W      34  width of transmitted segment (>=1); NUM_PARTS=ceil(IN_W/OUT_W), PAD=NUM_PARTS*OUT_W-IN_W
//   MSB_FIRST  1   1: emit most-significant segment first; 0: least-significant first
//   CNT_W      16  width of o_word_cnt
// PORTS
//   i_clk        in   1      clock
//   i_arst_n     in   1      asynchronous reset, active-low
//   i_rx_valid   in   1      RX FIFO non-empty; i_rx holds head word
//   i_rx         in   IN_W   RX FIFO head word
//   o_rx_rd      out  1      RX FIFO pop strobe, 1-cycle pulse per word
//   i_tx_rdy     in   1      TX FIFO can accept one segment
//   o_tx_data    out  OUT_W  segment to TX FIFO
//   o_tx_wr      out  1      TX FIFO write strobe, 1-cycle pulse per segment
//   o_busy       out  1      high whenever state != IDLE
//   o_word_cnt   out  CNT_W  number of fully transmitted words, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset: all outputs 0; state=IDLE; word register, part counter and o_word_cnt = 0. Reset is valid
//     at any time; mid-word reset abandons the word with no further o_tx_wr or o_rx_rd.
//   - Padded word P = {i_rx, PAD'b0} (zeros at LSBs), captured in LOAD.
//     Segment k (k=0 = MSB) = P[NUM_PARTS*OUT_W-1-k*OUT_W -: OUT_W].
//     MSB_FIRST=1 emits k=0..NUM_PARTS-1; MSB_FIRST=0 emits k=NUM_PARTS-1..0.
//   - FSM (one-hot), registered state, all outputs registered (glitch-free):
//     IDLE:     i_rx_valid -> LOAD.
//     LOAD:     capture P; part_cnt<=0; o_rx_rd=1 for exactly this cycle -> WAIT_RDY.
//     WAIT_RDY: o_tx_data = current segment (stable); i_tx_rdy sampled only here; 1 -> WRITE, else stay.
//     WRITE:    o_tx_wr=1 for exactly this cycle, o_tx_data unchanged.
//               part_cnt<NUM_PARTS-1: part_cnt++ -> WAIT_RDY.
//               part_cnt=NUM_PARTS-1: o_word_cnt++ -> LOAD if i_rx_valid, else IDLE.
//     Illegal state -> IDLE.
//   - o_tx_wr and o_rx_rd are flops decoded from next-state; never asserted in the same cycle.
//   - Latency: i_rx_valid rise in IDLE -> o_rx_rd 1 cycle later. With i_tx_rdy held high, first
//     o_tx_wr comes 3 cycles after i_rx_valid. Each further segment adds 2 cycles.
//     Back-to-back word: LOAD directly follows the last WRITE.
//   - i_tx_rdy low in WAIT_RDY: wait indefinitely, no timeout; data held.
//   - NUM_PARTS=1 (OUT_W>=IN_W): one segment per word, PAD zeros at LSBs.
//   - o_word_cnt wraps from 2^CNT_W-1 to 0 without flag.
// TESTING
//   1 Defaults. i_rx={34'h3_FFFF_FFFF,22'h0}, rdy=1 -> one o_rx_rd; o_tx_wr pulses with 34'h3_FFFF_FFFF
//     then 34'h0; o_word_cnt=1.
//   2 Defaults. i_rx=56'h3F_FFFF -> segments 34'h0 then 34'h3_FFFF_F000 (22 ones, 12 pad zeros).
//     MSB_FIRST=0 -> reverse order.
//   3 rdy low 20 cycles in WAIT_RDY of segment 2 -> no o_tx_wr, o_tx_data stable.
//     rdy high -> single o_tx_wr 1 cycle after rdy sampled.
//   4 Three words queued, rdy=1 -> o_rx_rd pulses 5 cycles apart, 6 o_tx_wr total, o_busy never drops,
//     o_word_cnt=3.
//   5 i_arst_n low during WRITE of segment 1 -> outputs 0 immediately. After release with
//     i_rx_valid=0: no writes, o_word_cnt=0.
//   6 IN_W=32, OUT_W=8, CNT_W=2: i_rx=32'h1122_3344 -> 8'h11,8'h22,8'h33,8'h44.
//     Five words -> o_word_cnt wraps to 1.

Source files
------------

// File: rtl/loop_interface_segmenter.sv
// Loopback segmenter: pops one word from the RX FIFO, pads it with zeros at the
// LSBs to a whole number of segments and writes the segments to the TX FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no word in flight, waiting for RX FIFO non-empty
// LOAD     | capture padded head word, pop strobe to RX FIFO
// WAIT_RDY | current segment presented on o_tx_data, waiting for TX ready
// WRITE    | write strobe for current segment, then next segment or word
module loop_interface_segmenter #(
    parameter int IN_W      = 56,
    parameter int OUT_W     = 34,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_rx_valid,
    input  logic [IN_W-1:0]  i_rx,
    output logic             o_rx_rd,
    input  logic             i_tx_rdy,
    output logic [OUT_W-1:0] o_tx_data,
    output logic             o_tx_wr,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_word_cnt
);

    localparam int NUM_PARTS = (IN_W + OUT_W - 1) / OUT_W;
    localparam int TOT_W     = NUM_PARTS * OUT_W;
    localparam int PART_W    = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam logic [PART_W-1:0] LAST_PART = PART_W'(NUM_PARTS - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        LOAD     = 4'b0010,
        WAIT_RDY = 4'b0100,
        WRITE    = 4'b1000
    } state_t;

    state_t             state, state_nxt;
    logic [TOT_W-1:0]   word_q, word_nxt, p_load;
    logic [PART_W-1:0]  part_q, part_nxt;
    logic [OUT_W-1:0]   data_nxt;
    logic               cnt_inc;

    // Segment emitted at position p of the word; k=0 is the most-significant slice.
    function automatic logic [OUT_W-1:0] seg_of(input logic [TOT_W-1:0] w,
                                                input logic [PART_W-1:0] p);
        int k;
        k = MSB_FIRST ? int'(p) : (NUM_PARTS - 1 - int'(p));
        return OUT_W'(w >> ((NUM_PARTS - 1 - k) * OUT_W));
    endfunction

    // Left-justify the received word so pad zeros land at the LSBs.
    always_comb begin
        p_load = '0;
        p_load[TOT_W-1 -: IN_W] = i_rx;
    end

    // Next-state, next word/part and the segment to present on the next cycle.
    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        part_nxt  = part_q;
        data_nxt  = o_tx_data;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_valid) state_nxt = LOAD;
            end
            LOAD: begin
                word_nxt  = p_load;
                part_nxt  = '0;
                data_nxt  = seg_of(p_load, '0);
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (i_tx_rdy) state_nxt = WRITE;
            end
            WRITE: begin
                if (part_q == LAST_PART) begin
                    cnt_inc   = 1'b1;
                    state_nxt = i_rx_valid ? LOAD : IDLE;
                end else begin
                    part_nxt  = part_q + PART_W'(1);
                    data_nxt  = seg_of(word_q, part_nxt);
                    state_nxt = WAIT_RDY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and strobes are all registered; strobes decode next-state.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= IDLE;
            word_q     <= '0;
            part_q     <= '0;
            o_tx_data  <= '0;
            o_rx_rd    <= 1'b0;
            o_tx_wr    <= 1'b0;
            o_busy     <= 1'b0;
            o_word_cnt <= '0;
        end else begin
            state     <= state_nxt;
            word_q    <= word_nxt;
            part_q    <= part_nxt;
            o_tx_data <= data_nxt;
            o_rx_rd   <= (state_nxt == LOAD);
            o_tx_wr   <= (state_nxt == WRITE);
            o_busy    <= (state_nxt != IDLE);
            if (cnt_inc) o_word_cnt <= o_word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_loop_interface_segmenter.sv
// Bench for loop_interface_segmenter: three instances (default widths MSB-first,
// default widths LSB-first, 32->8 with a 2-bit counter) fed from modelled RX FIFOs,
// with expected segments queued at push time and compared as writes appear.
module tb_loop_interface_segmenter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_rx_valid, a_rx_rd, a_rdy, a_tx_wr, a_busy;
    logic [55:0] a_rx;
    logic [33:0] a_tx_data;
    logic [15:0] a_cnt;

    logic        b_rx_valid, b_rx_rd, b_rdy, b_tx_wr, b_busy;
    logic [55:0] b_rx;
    logic [33:0] b_tx_data;
    logic [15:0] b_cnt;

    logic        c_rx_valid, c_rx_rd, c_rdy, c_tx_wr, c_busy;
    logic [31:0] c_rx;
    logic [7:0]  c_tx_data;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int words_a  = 0;
    int words_b  = 0;
    int words_c  = 0;

    logic [55:0] rxq_a[$];
    logic [55:0] rxq_b[$];
    logic [31:0] rxq_c[$];
    logic [33:0] expq_a[$];
    logic [33:0] expq_b[$];
    logic [7:0]  expq_c[$];
    bit rdp_a, rdp_b, rdp_c;

    loop_interface_segmenter #(.IN_W(56), .OUT_W(34), .MSB_FIRST(1'b1), .CNT_W(16)) u_a (
        .i_clk(clk), .i_arst_n(rst_n), .i_rx_valid(a_rx_valid), .i_rx(a_rx),
        .o_rx_rd(a_rx_rd), .i_tx_rdy(a_rdy), .o_tx_data(a_tx_data), .o_tx_wr(a_tx_wr),
        .o_busy(a_busy), .o_word_cnt(a_cnt));

    loop_interface_segmenter #(.IN_W(56), .OUT_W(34), .MSB_FIRST(1'b0), .CNT_W(16)) u_b (
        .i_clk(clk), .i_arst_n(rst_n), .i_rx_valid(b_rx_valid), .i_rx(b_rx),
        .o_rx_rd(b_rx_rd), .i_tx_rdy(b_rdy), .o_tx_data(b_tx_data), .o_tx_wr(b_tx_wr),
        .o_busy(b_busy), .o_word_cnt(b_cnt));

    loop_interface_segmenter #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .CNT_W(2)) u_c (
        .i_clk(clk), .i_arst_n(rst_n), .i_rx_valid(c_rx_valid), .i_rx(c_rx),
        .o_rx_rd(c_rx_rd), .i_tx_rdy(c_rdy), .o_tx_data(c_tx_data), .o_tx_wr(c_tx_wr),
        .o_busy(c_busy), .o_word_cnt(c_cnt));

    task automatic drive_rx();
        a_rx_valid = (rxq_a.size() != 0);
        a_rx       = a_rx_valid ? rxq_a[0] : '0;
        b_rx_valid = (rxq_b.size() != 0);
        b_rx       = b_rx_valid ? rxq_b[0] : '0;
        c_rx_valid = (rxq_c.size() != 0);
        c_rx       = c_rx_valid ? rxq_c[0] : '0;
    endtask

    task automatic push_a(input logic [55:0] w);
        rxq_a.push_back(w);
        expq_a.push_back(w[55:22]);
        expq_a.push_back({w[21:0], 12'h000});
        drive_rx();
    endtask

    task automatic push_b(input logic [55:0] w);
        rxq_b.push_back(w);
        expq_b.push_back({w[21:0], 12'h000});
        expq_b.push_back(w[55:22]);
        drive_rx();
    endtask

    task automatic push_c(input logic [31:0] w);
        rxq_c.push_back(w);
        expq_c.push_back(w[31:24]);
        expq_c.push_back(w[23:16]);
        expq_c.push_back(w[15:8]);
        expq_c.push_back(w[7:0]);
        drive_rx();
    endtask

    // One clock: RX FIFO pops after the capture edge, scoreboard compares each write.
    task automatic step();
        logic [33:0] ea;
        logic [7:0]  ec;
        @(posedge clk);
        #1;
        if (rdp_a && rxq_a.size() != 0) void'(rxq_a.pop_front());
        if (rdp_b && rxq_b.size() != 0) void'(rxq_b.pop_front());
        if (rdp_c && rxq_c.size() != 0) void'(rxq_c.pop_front());
        rdp_a = a_rx_rd;
        rdp_b = b_rx_rd;
        rdp_c = c_rx_rd;
        drive_rx();
        if (a_tx_wr) begin
            n_checks++;
            if (expq_a.size() == 0) $display("FAIL sb_a: unexpected write data=%h", a_tx_data);
            else begin
                ea = expq_a.pop_front();
                if (a_tx_data !== ea) $display("FAIL sb_a: data=%h expected %h", a_tx_data, ea);
                else n_pass++;
            end
        end
        if (b_tx_wr) begin
            n_checks++;
            if (expq_b.size() == 0) $display("FAIL sb_b: unexpected write data=%h", b_tx_data);
            else begin
                ea = expq_b.pop_front();
                if (b_tx_data !== ea) $display("FAIL sb_b: data=%h expected %h", b_tx_data, ea);
                else n_pass++;
            end
        end
        if (c_tx_wr) begin
            n_checks++;
            if (expq_c.size() == 0) $display("FAIL sb_c: unexpected write data=%h", c_tx_data);
            else begin
                ec = expq_c.pop_front();
                if (c_tx_data !== ec) $display("FAIL sb_c: data=%h expected %h", c_tx_data, ec);
                else n_pass++;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (expq_a.size() == 0 && expq_b.size() == 0 && expq_c.size() == 0 &&
                rxq_a.size() == 0 && rxq_b.size() == 0 && rxq_c.size() == 0 &&
                !a_busy && !b_busy && !c_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({a_rx_rd, a_tx_wr, a_busy} !== 3'b000) $display("FAIL reset_strobes: %b expected 000", {a_rx_rd, a_tx_wr, a_busy});
        else n_pass++;
        n_checks++;
        if (a_tx_data !== 34'h0) $display("FAIL reset_data: %h expected 0", a_tx_data);
        else n_pass++;
        n_checks++;
        if (a_cnt !== 16'h0 || c_cnt !== 2'h0) $display("FAIL reset_cnt: a=%0d c=%0d expected 0", a_cnt, c_cnt);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int rd_n, wr_n, first_rd, first_wr;
        rd_n = 0; wr_n = 0; first_rd = -1; first_wr = -1;
        push_a({34'h3_FFFF_FFFF, 22'h0});
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a_rx_rd) begin rd_n++; if (first_rd < 0) first_rd = i; end
            if (a_tx_wr) begin wr_n++; if (first_wr < 0) first_wr = i; end
        end
        words_a++;
        n_checks++;
        if (rd_n !== 1 || first_rd !== 1) $display("FAIL basic_rd: pulses=%0d at %0d expected 1 at 1", rd_n, first_rd);
        else n_pass++;
        n_checks++;
        if (wr_n !== 2 || first_wr !== 3) $display("FAIL basic_wr: pulses=%0d first at %0d expected 2 first at 3", wr_n, first_wr);
        else n_pass++;
        n_checks++;
        if (a_cnt !== 16'(words_a) || expq_a.size() != 0) $display("FAIL basic_cnt: cnt=%0d left=%0d expected %0d left 0", a_cnt, expq_a.size(), words_a);
        else n_pass++;
    endtask

    task automatic test_order();
        bit ok;
        push_a(56'h3F_FFFF);
        push_b(56'h3F_FFFF);
        push_b(56'h12_3456_789A_BCDE);
        wait_idle(40, ok);
        words_a++;
        words_b += 2;
        n_checks++;
        if (!ok) $display("FAIL order_done: timeout left_a=%0d left_b=%0d expected 0", expq_a.size(), expq_b.size());
        else n_pass++;
        n_checks++;
        if (a_cnt !== 16'(words_a) || b_cnt !== 16'(words_b)) $display("FAIL order_cnt: a=%0d b=%0d expected %0d %0d", a_cnt, b_cnt, words_a, words_b);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok, found, stable;
        found = 1'b0;
        stable = 1'b1;
        push_a(56'hAB_CDEF_0123_4567);
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (a_tx_wr) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL stall_first_wr: no write within 10 cycles");
        else n_pass++;
        a_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_tx_wr || !a_busy || expq_a.size() != 1) stable = 1'b0;
            else if (a_tx_data !== expq_a[0]) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL stall_hold: wr=%b busy=%b data=%h not held", a_tx_wr, a_busy, a_tx_data);
        else n_pass++;
        a_rdy = 1'b1;
        step();
        n_checks++;
        if (a_tx_wr !== 1'b1) $display("FAIL stall_release: wr=%b expected 1", a_tx_wr);
        else n_pass++;
        step();
        n_checks++;
        if (a_tx_wr !== 1'b0) $display("FAIL stall_single: wr=%b expected 0", a_tx_wr);
        else n_pass++;
        wait_idle(20, ok);
        words_a++;
        n_checks++;
        if (!ok || a_cnt !== 16'(words_a)) $display("FAIL stall_cnt: cnt=%0d done=%b expected %0d", a_cnt, ok, words_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rd_at[$];
        int wr_n;
        bit drop;
        wr_n = 0;
        drop = 1'b0;
        for (int j = 0; j < 3; j++) push_a(56'({$urandom(), $urandom()}));
        for (int i = 1; i <= 60; i++) begin
            step();
            if (a_rx_rd) rd_at.push_back(i);
            if (a_tx_wr) wr_n++;
            if (!a_busy) drop = 1'b1;
            if (expq_a.size() == 0) break;
        end
        words_a += 3;
        n_checks++;
        if (rd_at.size() != 3) $display("FAIL b2b_rd_count: %0d expected 3", rd_at.size());
        else if (rd_at[1] - rd_at[0] != 5 || rd_at[2] - rd_at[1] != 5)
            $display("FAIL b2b_rd_spacing: %0d,%0d expected 5,5", rd_at[1] - rd_at[0], rd_at[2] - rd_at[1]);
        else n_pass++;
        n_checks++;
        if (wr_n != 6 || drop) $display("FAIL b2b_wr: writes=%0d busy_drop=%b expected 6 0", wr_n, drop);
        else n_pass++;
        step();
        n_checks++;
        if (a_cnt !== 16'(words_a) || a_busy !== 1'b0) $display("FAIL b2b_cnt: cnt=%0d busy=%b expected %0d 0", a_cnt, a_busy, words_a);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        push_c(32'h1122_3344);
        wait_idle(30, ok);
        words_c++;
        n_checks++;
        if (!ok || c_cnt !== 2'd1) $display("FAIL wrap_first: cnt=%0d done=%b expected 1", c_cnt, ok);
        else n_pass++;
        for (int j = 0; j < 4; j++) push_c($urandom());
        wait_idle(100, ok);
        words_c += 4;
        n_checks++;
        if (!ok || c_cnt !== 2'(words_c % 4)) $display("FAIL wrap_cnt: cnt=%0d done=%b expected %0d", c_cnt, ok, words_c % 4);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        int act;
        found = 1'b0;
        act = 0;
        push_a(56'h55_AA55_AA55_AA55);
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (a_tx_wr) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL rstmid_wr: no write within 10 cycles");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_rx_rd, a_tx_wr, a_busy} !== 3'b000 || a_tx_data !== 34'h0 || a_cnt !== 16'h0)
            $display("FAIL rstmid_outputs: rd=%b wr=%b busy=%b data=%h cnt=%0d expected all 0", a_rx_rd, a_tx_wr, a_busy, a_tx_data, a_cnt);
        else n_pass++;
        expq_a.delete(); rxq_a.delete(); expq_b.delete(); rxq_b.delete(); expq_c.delete(); rxq_c.delete();
        rdp_a = 1'b0; rdp_b = 1'b0; rdp_c = 1'b0;
        words_a = 0; words_b = 0; words_c = 0;
        drive_rx();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_tx_wr || a_rx_rd || a_busy) act++;
        end
        n_checks++;
        if (act != 0 || a_cnt !== 16'(words_a)) $display("FAIL rstmid_after: activity=%0d cnt=%0d expected 0 0", act, a_cnt);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rdy = 1'b1;
        b_rdy = 1'b1;
        c_rdy = 1'b1;
        rdp_a = 1'b0;
        rdp_b = 1'b0;
        rdp_c = 1'b0;
        drive_rx();
        test_reset();
        test_basic();
        test_order();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
